// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master.
// Holds the FSM state encoding, the response payload struct and the
// default APB address/data widths that the RAM slave and the bench use too.
package apb_cmd_master_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master_timeout_cnt.sv
// ACCESS-phase watchdog counter for the APB command master.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   clear   in  forces the count back to zero
//   enable  in  counts one ACCESS cycle
//   expired out count has reached TIMEOUT_CYC-1, i.e. this is the last
//               ACCESS cycle allowed without pready
module apb_timeout_cnt #(
  parameter  int TIMEOUT_CYC = 16,
  localparam int CNT_W       = $clog2(TIMEOUT_CYC) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at the expiry value so a stalled FSM can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB master stage: turns single read/write commands from a valid/ready
// port into one APB transfer each (SETUP then ACCESS, waiting for pready
// with a timeout guard) and returns read data plus error status on a
// valid/ready response port.
// Ports:
//   pclk, preset                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err/rsp_timeout  response payload
//   psel/penable/pwrite/paddr/pwdata   APB request outputs
//   prdata/pready/pslverr              APB slave response inputs
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  apb_rsp_t          rsp_q, rsp_d;
  logic              tmo_expired;

  // The watchdog only runs while in ACCESS; any other state rearms it.
  apb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk    (pclk),
    .reset  (preset),
    .clear  (state_q != ACCESS),
    .enable (state_q == ACCESS),
    .expired(tmo_expired)
  );

  // Next-state and payload capture. pready wins over the timeout in the
  // same cycle, and read data is forced to zero for writes and errors so a
  // consumer never sees stale or garbage data on a failed transfer.
  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rsp_d    = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_d.rdata   = (pwrite_q || pslverr) ? '0 : APB_DATA_W'(prdata);
          rsp_d.err     = pslverr;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (tmo_expired) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rsp_q    <= rsp_d;
    end
  end

  // cmd_ready is gated by preset so no command slips in during a reset cycle.
  assign cmd_ready   = (state_q == IDLE) && !preset;
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule
